// File: rtl/key_pkg.sv
// Shared defaults and helpers for the key toggle bank.
package key_pkg;

  localparam int N_KEYS_DEF          = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

  // Counter width able to hold 0..cycles inclusive.
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key channel: two-flop synchronizer followed by a stable-level debouncer.
// rise is a combinational strobe, high during the cycle whose closing edge
// loads stable 0->1, so the parent can register its reactions on that same edge.
import key_pkg::*;

module key_debounce #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic stable,
  output logic rise
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);
  // Synchronizer idles at the released pin level so reset never looks like a press.
  localparam logic          IDLE_LVL = KEY_ACTIVE_LOW;

  logic          meta;
  logic          sync_raw;
  logic          sync_k;
  logic [CW-1:0] cnt;
  logic          accept;

  // Two-flop synchronizer on the raw pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta     <= IDLE_LVL;
      sync_raw <= IDLE_LVL;
    end else begin
      meta     <= key;
      sync_raw <= meta;
    end
  end

  assign sync_k = KEY_ACTIVE_LOW ? ~sync_raw : sync_raw;

  // The edge that would bring the count to DEBOUNCE_CYCLES is the accept edge.
  assign accept = (sync_k != stable) && (cnt == LAST_CNT);
  assign rise   = accept & sync_k;

  // Count consecutive disagreeing cycles; any agreement discards the partial count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (sync_k == stable) begin
      cnt <= '0;
    end else if (accept) begin
      stable <= sync_k;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/key_toggle_bank.sv
// Bank of debounced pushbuttons, each toggling its own mode bit per press.
import key_pkg::*;

module key_toggle_bank #(
  parameter int N_KEYS          = N_KEYS_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key,
  input  logic              clr,
  output logic [N_KEYS-1:0] mode,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse
);

  logic [N_KEYS-1:0] rise;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .KEY_ACTIVE_LOW  (KEY_ACTIVE_LOW)
    ) u_debounce (
      .clk    (clk),
      .rst_n  (rst_n),
      .key    (key[g]),
      .stable (pressed[g]),
      .rise   (rise[g])
    );
  end

  // Pulse and toggle land on the same edge as the debounced level rising; clr wins over toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      press_pulse <= '0;
      mode        <= '0;
    end else begin
      press_pulse <= rise;
      mode        <= clr ? '0 : (mode ^ rise);
    end
  end

endmodule

// File: tb/tb_key_toggle_bank.sv
// Directed bench for key_toggle_bank with a per-cycle scoreboard model.
module tb_key_toggle_bank;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] key;
  logic       clr;
  logic [1:0] mode;
  logic [1:0] pressed;
  logic [1:0] press_pulse;

  int errors = 0;
  int checks = 0;
  string phase = "init";

  typedef struct {
    logic [1:0] pressed;
    logic [1:0] pulse;
    logic [1:0] mode;
  } exp_t;

  exp_t sbq[$];

  // Reference model state
  logic [1:0] m_s1, m_s2, m_st, m_pulse, m_mode;
  int         m_cnt[2];

  key_toggle_bank #(
    .N_KEYS          (2),
    .DEBOUNCE_CYCLES (D),
    .KEY_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key         (key),
    .clr         (clr),
    .mode        (mode),
    .pressed     (pressed),
    .press_pulse (press_pulse)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s/%s: observed=%b expected=%b", phase, tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_s1 = '0; m_s2 = '0; m_st = '0; m_pulse = '0; m_mode = '0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  // Advance the model by one edge, push its prediction, clock the DUT, pop and compare.
  task automatic tick();
    exp_t       e;
    exp_t       got;
    logic [1:0] rise;
    rise = '0;
    if (!rst_n) begin
      model_zero();
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (m_s2[k] == m_st[k]) m_cnt[k] = 0;
        else if (m_cnt[k] == D - 1) begin
          m_st[k]  = m_s2[k];
          m_cnt[k] = 0;
          rise[k]  = m_s2[k];
        end else m_cnt[k]++;
      end
      m_pulse = rise;
      m_mode  = clr ? 2'b00 : (m_mode ^ rise);
      m_s2    = m_s1;
      m_s1    = ~key;
    end
    e.pressed = m_st; e.pulse = m_pulse; e.mode = m_mode;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sbq.size() > 0) else begin
      errors++;
      $error("FAIL %s/scoreboard: observed=empty expected=entry", phase);
    end
    if (sbq.size() > 0) begin
      got = sbq.pop_front();
      check("pressed", pressed, got.pressed);
      check("press_pulse", press_pulse, got.pulse);
      check("mode", mode, got.mode);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int pulses;

  initial begin
    // Reset state
    phase = "reset";
    rst_n = 1'b0; key = 2'b11; clr = 1'b0;
    model_zero();
    #3;
    check("pressed", pressed, 2'b00);
    check("press_pulse", press_pulse, 2'b00);
    check("mode", mode, 2'b00);
    idle(2);
    rst_n = 1'b1;
    idle(3);

    // Clean press on key[0]: accepted on the 6th edge
    phase = "clean_press";
    key = 2'b10;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 4) check("pressed_early", {1'b0, pressed[0]}, 2'b00);
      if (i == 5) begin
        check("pressed_at6", {1'b0, pressed[0]}, 2'b01);
        check("pulse_at6", press_pulse, 2'b01);
        check("mode_at6", mode, 2'b01);
      end
      if (i == 6) check("pulse_one_cycle", press_pulse, 2'b00);
    end
    key = 2'b11;
    idle(10);

    // Bounce rejection on key[1]
    phase = "bounce";
    for (int i = 0; i < 16; i++) begin
      key[1] = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      check("no_press1", {pressed[1], press_pulse[1]}, 2'b00);
      check("no_mode1", {1'b0, mode[1]}, 2'b00);
    end
    key = 2'b11;
    idle(10);

    // Double press on key[0]: mode 0->1->0, pulses only on presses
    phase = "double_press";
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("mode_cleared", mode, 2'b00);
    pulses = 0;
    key = 2'b10;
    for (int i = 0; i < 10; i++) begin tick(); pulses += int'(press_pulse[0]); end
    check("mode_after_p1", {1'b0, mode[0]}, 2'b01);
    key = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_release_pulse", press_pulse, 2'b00);
    end
    check("mode_after_r1", {1'b0, mode[0]}, 2'b01);
    key = 2'b10;
    for (int i = 0; i < 10; i++) begin tick(); pulses += int'(press_pulse[0]); end
    check("mode_after_p2", {1'b0, mode[0]}, 2'b00);
    check("pulse_count", 2'(pulses), 2'd2);
    key = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("no_release_pulse", press_pulse, 2'b00);
    end

    // clr on the same edge as the key[1] toggle
    phase = "clr_vs_toggle";
    key = 2'b01;
    for (int i = 0; i < 10; i++) begin
      clr = (i == 5);
      tick();
      if (i == 5) begin
        check("mode1_cleared", {1'b0, mode[1]}, 2'b00);
        check("pulse1_kept", {1'b0, press_pulse[1]}, 2'b01);
        check("pressed1_kept", {1'b0, pressed[1]}, 2'b01);
      end
    end
    clr = 1'b0;
    key = 2'b11;
    idle(10);

    // Simultaneous press on both channels
    phase = "simultaneous";
    key = 2'b00;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 5) begin
        check("mode_both", mode, 2'b11);
        check("pulse_both", press_pulse, 2'b11);
      end
    end
    key = 2'b11;
    idle(10);

    // Reset in the middle of a debounce count
    phase = "reset_mid";
    key = 2'b10;
    idle(5);
    rst_n = 1'b0;
    model_zero();
    #1;
    check("pressed_in_rst", pressed, 2'b00);
    check("pulse_in_rst", press_pulse, 2'b00);
    check("mode_in_rst", mode, 2'b00);
    idle(2);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 4) check("pressed_early", pressed, 2'b00);
      if (i == 5) begin
        check("pressed_at6", pressed, 2'b01);
        check("pulse_at6", press_pulse, 2'b01);
        check("mode_at6", mode, 2'b01);
      end
    end
    key = 2'b11;
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
